marker_extrema_tracker: RTL and testbench

MARKER_EXTREMA_TRACKER -- requirements
Module: marker_extrema_tracker

---
 rtl/marker_extrema_tracker_pkg.sv | 69 ++++++
 rtl/marker_extrema_tracker_if.sv | 31 +++
 rtl/marker_extrema_tracker_classifier.sv | 17 +
 rtl/marker_extrema_tracker.sv | 182 ++++++++++++++++++
 tb/tb_marker_extrema_tracker.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/marker_extrema_tracker_pkg.sv
// Shared types and constants for the marker extrema tracker.
// Coordinates are 11 bits; 2023 marks an extreme point that was not found.
package tracker_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [19:0] count_t;

    localparam coord_t NOT_FOUND = 11'd2023;
    localparam count_t COUNT_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_PUBLISH
    } state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // Running per-frame accumulators; found marks that at least one match was absorbed.
    typedef struct packed {
        point_t left;
        point_t right;
        point_t up;
        point_t down;
        count_t count;
        logic   found;
    } extrema_t;

    typedef struct packed {
        point_t left;
        point_t right;
        point_t up;
        point_t down;
        count_t count;
    } publish_t;

    function automatic point_t point_not_found();
        point_t p;
        p.x = NOT_FOUND;
        p.y = NOT_FOUND;
        return p;
    endfunction

    function automatic extrema_t extrema_clear();
        extrema_t e;
        e.left  = point_not_found();
        e.right = point_not_found();
        e.up    = point_not_found();
        e.down  = point_not_found();
        e.count = '0;
        e.found = 1'b0;
        return e;
    endfunction

    function automatic publish_t publish_clear();
        publish_t p;
        p.left  = point_not_found();
        p.right = point_not_found();
        p.up    = point_not_found();
        p.down  = point_not_found();
        p.count = '0;
        return p;
    endfunction

endpackage

// File: rtl/marker_extrema_tracker_if.sv
// Pixel stream in / extreme points out. The source drives i_* (master),
// the tracker consumes them and drives o_* (slave).
interface marker_extrema_tracker_if;
    import tracker_pkg::*;

    logic       i_enable;
    logic       i_sof;
    logic       i_eof;
    logic       i_valid;
    coord_t     i_x;
    coord_t     i_y;
    logic [7:0] i_rgb [3];

    coord_t     o_left  [2];
    coord_t     o_right [2];
    coord_t     o_up    [2];
    coord_t     o_down  [2];
    logic       o_predict_valid;
    count_t     o_pixel_count;

    modport master (
        output i_enable, i_sof, i_eof, i_valid, i_x, i_y, i_rgb,
        input  o_left, o_right, o_up, o_down, o_predict_valid, o_pixel_count
    );

    modport slave (
        input  i_enable, i_sof, i_eof, i_valid, i_x, i_y, i_rgb,
        output o_left, o_right, o_up, o_down, o_predict_valid, o_pixel_count
    );

endinterface

// File: rtl/marker_extrema_tracker_classifier.sv
// Combinational colour-threshold test: a valid pixel that is red enough and
// low enough in green and blue counts as a marker pixel.
module marker_pixel_classifier #(
    parameter logic [7:0] R_MIN = 8'd150,
    parameter logic [7:0] G_MAX = 8'd90,
    parameter logic [7:0] B_MAX = 8'd90
) (
    input  logic       valid_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       match_o
);

    assign match_o = valid_i && (r_i >= R_MIN) && (g_i <= G_MAX) && (b_i <= B_MAX);

endmodule

// File: rtl/marker_extrema_tracker.sv
// Tracks the left/right/up/down extreme marker pixels of each frame and
// publishes them with a one-cycle pulse two cycles after end-of-frame.
module marker_extrema_tracker #(
    parameter logic [7:0]  R_MIN     = 8'd150,
    parameter logic [7:0]  G_MAX     = 8'd90,
    parameter logic [7:0]  B_MAX     = 8'd90,
    parameter logic [19:0] MIN_COUNT = 20'd16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    marker_extrema_tracker_if.slave   bus
);
    import tracker_pkg::*;

    logic     pix_match;
    state_t   state_q, state_d;
    logic     s1_match_q, s1_match_d;
    coord_t   s1_x_q, s1_x_d;
    coord_t   s1_y_q, s1_y_d;
    extrema_t acc_q, acc_d;
    publish_t pub_q, pub_d;

    logic     scan_clear;
    logic     capture_en;
    logic     absorb_en;
    logic     publish_load;
    logic     predict_valid;

    marker_pixel_classifier #(
        .R_MIN (R_MIN),
        .G_MAX (G_MAX),
        .B_MAX (B_MAX)
    ) u_classifier (
        .valid_i (bus.i_valid),
        .r_i     (bus.i_rgb[0]),
        .g_i     (bus.i_rgb[1]),
        .b_i     (bus.i_rgb[2]),
        .match_o (pix_match)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.i_sof && bus.i_enable) state_d = S_SCAN;
            S_SCAN:    if (bus.i_eof) state_d = S_DRAIN;
            S_DRAIN:   state_d = S_PUBLISH;
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A restart sof in S_SCAN loses to a simultaneous eof, so the frame still publishes.
    always_comb begin
        scan_clear    = 1'b0;
        capture_en    = 1'b0;
        absorb_en     = 1'b0;
        publish_load  = 1'b0;
        predict_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                scan_clear = bus.i_sof && bus.i_enable;
            end
            S_SCAN: begin
                capture_en = 1'b1;
                absorb_en  = 1'b1;
                scan_clear = bus.i_sof && !bus.i_eof;
            end
            S_DRAIN: begin
                absorb_en    = 1'b1;
                publish_load = 1'b1;
            end
            S_PUBLISH: begin
                predict_valid = 1'b1;
            end
            default: begin
                predict_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_match_d = pix_match && capture_en;
        s1_x_d     = bus.i_x;
        s1_y_d     = bus.i_y;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_match_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_match_q <= s1_match_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
        end
    end

    // Raster order makes strict compares keep the first hit and >= keep the last.
    always_comb begin
        acc_d = acc_q;
        if (scan_clear) begin
            acc_d = extrema_clear();
        end else if (absorb_en && s1_match_q) begin
            if (!acc_q.found || (s1_x_q < acc_q.left.x)) begin
                acc_d.left.x = s1_x_q;
                acc_d.left.y = s1_y_q;
            end
            if (!acc_q.found || (s1_x_q > acc_q.right.x)) begin
                acc_d.right.x = s1_x_q;
                acc_d.right.y = s1_y_q;
            end
            if (!acc_q.found) begin
                acc_d.up.x = s1_x_q;
                acc_d.up.y = s1_y_q;
            end
            if (!acc_q.found || (s1_y_q >= acc_q.down.y)) begin
                acc_d.down.x = s1_x_q;
                acc_d.down.y = s1_y_q;
            end
            if (acc_q.count != COUNT_MAX) begin
                acc_d.count = acc_q.count + 20'd1;
            end
            acc_d.found = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= extrema_clear();
        end else begin
            acc_q <= acc_d;
        end
    end

    // Load from acc_d so the pixel absorbed during S_DRAIN is included.
    always_comb begin
        pub_d = pub_q;
        if (publish_load) begin
            pub_d.count = acc_d.count;
            if (acc_d.count < MIN_COUNT) begin
                pub_d.left  = point_not_found();
                pub_d.right = point_not_found();
                pub_d.up    = point_not_found();
                pub_d.down  = point_not_found();
            end else begin
                pub_d.left  = acc_d.left;
                pub_d.right = acc_d.right;
                pub_d.up    = acc_d.up;
                pub_d.down  = acc_d.down;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pub_q <= publish_clear();
        end else begin
            pub_q <= pub_d;
        end
    end

    assign bus.o_left[0]       = pub_q.left.x;
    assign bus.o_left[1]       = pub_q.left.y;
    assign bus.o_right[0]      = pub_q.right.x;
    assign bus.o_right[1]      = pub_q.right.y;
    assign bus.o_up[0]         = pub_q.up.x;
    assign bus.o_up[1]         = pub_q.up.y;
    assign bus.o_down[0]       = pub_q.down.x;
    assign bus.o_down[1]       = pub_q.down.y;
    assign bus.o_pixel_count   = pub_q.count;
    assign bus.o_predict_valid = predict_valid;

endmodule

// File: tb/tb_marker_extrema_tracker.sv
// Directed bench for marker_extrema_tracker: table of single-pixel frames plus
// hand-written frame sequences for restart, reset, enable and timing corners.
module tb_marker_extrema_tracker;
    import tracker_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    marker_extrema_tracker_if bus ();

    marker_extrema_tracker #(
        .R_MIN     (8'd150),
        .G_MAX     (8'd90),
        .B_MAX     (8'd90),
        .MIN_COUNT (20'd16)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        int lx, ly, rx, ry, ux, uy, dx, dy, cnt;
    } exp_t;

    typedef struct {
        logic [7:0] r, g, b;
        int         exp_cnt;
    } pixvec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    always @(negedge i_clk) begin
        if (bus.o_predict_valid === 1'b1) pulse_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t nf(input int cnt);
        exp_t e;
        e = '{lx: 2023, ly: 2023, rx: 2023, ry: 2023, ux: 2023, uy: 2023,
              dx: 2023, dy: 2023, cnt: cnt};
        return e;
    endfunction

    function automatic exp_t mk(input int lx, ly, rx, ry, ux, uy, dx, dy, cnt);
        exp_t e;
        e = '{lx: lx, ly: ly, rx: rx, ry: ry, ux: ux, uy: uy, dx: dx, dy: dy, cnt: cnt};
        return e;
    endfunction

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".left.x"},  int'(bus.o_left[0]),  e.lx);
        chk({tag, ".left.y"},  int'(bus.o_left[1]),  e.ly);
        chk({tag, ".right.x"}, int'(bus.o_right[0]), e.rx);
        chk({tag, ".right.y"}, int'(bus.o_right[1]), e.ry);
        chk({tag, ".up.x"},    int'(bus.o_up[0]),    e.ux);
        chk({tag, ".up.y"},    int'(bus.o_up[1]),    e.uy);
        chk({tag, ".down.x"},  int'(bus.o_down[0]),  e.dx);
        chk({tag, ".down.y"},  int'(bus.o_down[1]),  e.dy);
        chk({tag, ".count"},   int'(bus.o_pixel_count), e.cnt);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_sof    = 1'b0;
        bus.i_eof    = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_x      = '0;
        bus.i_y      = '0;
        bus.i_rgb[0] = 8'd0;
        bus.i_rgb[1] = 8'd0;
        bus.i_rgb[2] = 8'd0;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic eof);
        bus.i_valid  = 1'b1;
        bus.i_x      = 11'(x);
        bus.i_y      = 11'(y);
        bus.i_rgb[0] = r;
        bus.i_rgb[1] = g;
        bus.i_rgb[2] = b;
        bus.i_eof    = eof;
        bus.i_sof    = 1'b0;
        step();
        clear_in();
    endtask

    task automatic ctl(input logic sof, input logic eof);
        bus.i_valid = 1'b0;
        bus.i_sof   = sof;
        bus.i_eof   = eof;
        step();
        clear_in();
    endtask

    // Called just after the edge that closed the eof cycle.
    task automatic expect_publish(input string tag, input exp_t e);
        chk({tag, ".pulse_eof+1"}, int'(bus.o_predict_valid), 0);
        step();
        chk({tag, ".pulse_eof+2"}, int'(bus.o_predict_valid), 1);
        chk_outs(tag, e);
        step();
        chk({tag, ".pulse_eof+3"}, int'(bus.o_predict_valid), 0);
        chk({tag, ".hold.count"}, int'(bus.o_pixel_count), e.cnt);
    endtask

    // 9x9 window of background with a red 5x5 block at (x0..x0+4, y0..y0+4); eof on last pixel.
    task automatic block_frame(input int x0, input int y0, input logic with_sof);
        if (with_sof) ctl(1'b1, 1'b0);
        for (int y = y0 - 2; y <= y0 + 6; y++) begin
            for (int x = x0 - 2; x <= x0 + 6; x++) begin
                automatic logic inb = (x >= x0) && (x <= x0 + 4) && (y >= y0) && (y <= y0 + 4);
                automatic logic last = (y == y0 + 6) && (x == x0 + 6);
                if (inb) pix(x, y, 8'd255, 8'd0, 8'd0, last);
                else     pix(x, y, 8'd10, 8'd10, 8'd10, last);
            end
        end
    endtask

    // Irregular 18-pixel marker; caller supplies eof.
    task automatic shape_frame(input logic with_sof);
        if (with_sof) ctl(1'b1, 1'b0);
        for (int x = 30; x <= 37; x++) pix(x, 20, 8'd200, 8'd50, 8'd50, 1'b0);
        pix(20, 21, 8'd100, 8'd50, 8'd50, 1'b0);
        for (int x = 25; x <= 28; x++) pix(x, 21, 8'd200, 8'd50, 8'd50, 1'b0);
        for (int x = 35; x <= 40; x++) pix(x, 22, 8'd200, 8'd50, 8'd50, 1'b0);
        pix(45, 22, 8'd200, 8'd95, 8'd50, 1'b0);
    endtask

    pixvec_t vecs [8];
    exp_t    exp_block;
    exp_t    exp_shape;
    int      p0;

    initial begin
        vecs[0] = '{r: 8'd150, g: 8'd90, b: 8'd90, exp_cnt: 1};
        vecs[1] = '{r: 8'd149, g: 8'd90, b: 8'd90, exp_cnt: 0};
        vecs[2] = '{r: 8'd200, g: 8'd91, b: 8'd0,  exp_cnt: 0};
        vecs[3] = '{r: 8'd150, g: 8'd90, b: 8'd91, exp_cnt: 0};
        vecs[4] = '{r: 8'd255, g: 8'd0,  b: 8'd0,  exp_cnt: 1};
        vecs[5] = '{r: 8'd0,   g: 8'd0,  b: 8'd0,  exp_cnt: 0};
        vecs[6] = '{r: 8'd255, g: 8'd90, b: 8'd90, exp_cnt: 1};
        vecs[7] = '{r: 8'd150, g: 8'd0,  b: 8'd90, exp_cnt: 1};

        exp_block = mk(100, 200, 104, 200, 100, 200, 104, 204, 25);
        exp_shape = mk(25, 21, 40, 22, 30, 20, 40, 22, 18);

        bus.i_enable = 1'b1;
        clear_in();
        i_rst_n = 1'b0;
        step();
        step();
        chk("reset.pulse", int'(bus.o_predict_valid), 0);
        chk_outs("reset", nf(0));
        i_rst_n = 1'b1;
        step();

        // Basic 5x5 block
        p0 = pulse_cnt;
        block_frame(100, 200, 1'b1);
        expect_publish("block", exp_block);
        chk("block.pulses", pulse_cnt - p0, 1);

        // Irregular shape; sof and eof together in S_SCAN publish, then stray eof in idle
        p0 = pulse_cnt;
        shape_frame(1'b1);
        ctl(1'b1, 1'b1);
        expect_publish("shape", exp_shape);
        ctl(1'b0, 1'b1);
        step();
        step();
        step();
        chk("shape.pulses", pulse_cnt - p0, 1);
        chk_outs("shape.idle_hold", exp_shape);

        // Ten matches: below MIN_COUNT
        ctl(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) pix(200 + i, 300, 8'd255, 8'd0, 8'd0, i == 9);
        expect_publish("ten", nf(10));

        // Threshold table, one pixel per frame
        for (int i = 0; i < 8; i++) begin
            ctl(1'b1, 1'b0);
            pix(300, 100, vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
            expect_publish($sformatf("vec%0d", i), nf(vecs[i].exp_cnt));
        end

        // Boundary pixels in one frame
        ctl(1'b1, 1'b0);
        pix(10, 5, 8'd150, 8'd90, 8'd90, 1'b0);
        pix(11, 5, 8'd149, 8'd90, 8'd90, 1'b0);
        pix(12, 5, 8'd200, 8'd91, 8'd0, 1'b1);
        expect_publish("boundary", nf(1));

        // Restart: aborted partial frame must not leak into the second frame
        p0 = pulse_cnt;
        ctl(1'b1, 1'b0);
        for (int x = 10; x < 30; x++) pix(x, 50, 8'd255, 8'd0, 8'd0, 1'b0);
        ctl(1'b1, 1'b0);
        block_frame(100, 200, 1'b0);
        expect_publish("restart", exp_block);
        step();
        chk("restart.pulses", pulse_cnt - p0, 1);

        // Reset mid-scan
        ctl(1'b1, 1'b0);
        for (int x = 10; x < 20; x++) pix(x, 60, 8'd255, 8'd0, 8'd0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk_outs("rst_mid", nf(0));
        step();
        step();
        chk("rst_mid.pulse", int'(bus.o_predict_valid), 0);
        i_rst_n = 1'b1;
        p0 = pulse_cnt;
        ctl(1'b0, 1'b1);
        step();
        step();
        step();
        chk("rst_mid.no_pulse", pulse_cnt - p0, 0);
        chk_outs("rst_mid.hold", nf(0));
        block_frame(100, 200, 1'b1);
        expect_publish("after_rst", exp_block);

        // Enable drops mid-frame: frame still completes
        ctl(1'b1, 1'b0);
        bus.i_enable = 1'b0;
        shape_frame(1'b0);
        ctl(1'b0, 1'b1);
        expect_publish("en_drop", exp_shape);

        // Enable low: sof/eof frame must not publish
        p0 = pulse_cnt;
        block_frame(100, 200, 1'b1);
        step();
        step();
        step();
        chk("en_low.no_pulse", pulse_cnt - p0, 0);
        chk_outs("en_low.hold", exp_shape);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
